fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
Parametrised forwarding and load-use hazard unit for the RISC pipeline.
- Tracks in-flight destination registers in an internal DEPTH-stage tag pipeline.
- Generates per-source forwarding selects for NUM_SRC operands and a load-use stall.
- Sits at decode/issue and drives the operand bypass muxes and the pipeline stall/bubble control.

Parameters:
- AW, 3: register address width.
- NUM_SRC, 2: number of source operands checked per issued instruction.
- DEPTH, 3: number of in-flight stages that can forward, youngest = stage 0.
- LOAD_LAT, 1: a load's data is not forwardable from stages 0..LOAD_LAT-1. Legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- issue_valid  in  1  decode presents a valid instruction.
- src_addr  in  NUM_SRC*AW  source register addresses, source k at bits [k*AW +: AW].
- src_used  in  NUM_SRC  source k is actually read.
- dst_wr_en  in  1  issued instruction writes the register file.
- dst_addr  in  AW  issued instruction destination.
- dst_is_load  in  1  issued instruction is a load.
- pipe_hold  in  1  external freeze; tag pipeline holds.
- flush  in  1  kill all in-flight entries.
- fwd_sel  out  NUM_SRC*SW  SW = $clog2(DEPTH+1). 0 = register file; i+1 = forward from stage i.
- stall  out  1  load-use hazard; decode must hold and a bubble is inserted.
- stall_count  out  32  stall-cycle counter (see Optional Feature).

Behaviour:
- State: DEPTH entries of {valid, addr[AW], is_load}.
- Reset (async, rst=1): all entries invalid. This forces fwd_sel=0, stall=0 and stall_count=0, and they stay so while rst=1.
- Register update at posedge clk, in priority order:
  - flush: all entries invalid. flush wins over pipe_hold.
  - else pipe_hold: entries unchanged.
  - else shift: entry[i] <= entry[i-1] for i>0. entry[0] <= {1, dst_addr, dst_is_load} when issue_valid & dst_wr_en & ~stall; otherwise a bubble (invalid).
  - The oldest entry is dropped, because it has written back and is now in the register file.
- Match (combinational, per source k): entry i matches when valid & src_used[k] & issue_valid & (addr == src_addr[k]).
- Youngest-first priority: the lowest matching index i wins.
  - If the winner is a load and i < LOAD_LAT, the source is not ready and fwd_sel[k] = 0.
  - Otherwise fwd_sel[k] = i+1.
  - No match gives fwd_sel[k] = 0.
  - An older ready match never overrides a younger unready load.
- stall = OR over all sources of "winner not ready". It is purely combinational from the current entries and inputs, so latency is 0 cycles.
- A stall persists until the load advances past stage LOAD_LAT-1. That is LOAD_LAT - i cycles for a winner at stage i, with no pipe_hold.
- During pipe_hold, stall and fwd_sel still reflect the current state; no bubble is inserted.
- issue_valid=0: fwd_sel all 0, stall=0.
- An instruction whose destination equals its own source is not self-matched; only existing entries are compared.
- Register address 0 is treated like any other register.

Optional Feature:
FWD_PERF_CNT_EN.
- Defined: stall_count increments on every clock with stall=1 & ~pipe_hold, saturates at 0xFFFFFFFF, and clears on rst only (flush does not clear it).
- Undefined: stall_count is tied to 0 and no counter logic is built.

Decomposition:
- Package fwd_pkg: entry struct typedef {valid, addr, is_load}; constant FWD_SEL_RF = 0; sel-width function clog2(DEPTH+1).
- Sub-module fwd_src_match: per-source comparator array plus youngest-first priority encoder, outputting {sel, not_ready}. Instantiated NUM_SRC times by generate.
- The top level holds the tag pipeline, the stall OR and the optional counter.

Test Plan:
All scenarios use AW=3, NUM_SRC=2, DEPTH=3, LOAD_LAT=1.
1. ALU writes r3, then consumer issues src0=r3 on consecutive cycles 1/2/3/4 -> fwd_sel[0] = 1/2/3/0, stall=0 throughout.
2. Load r5, then next-cycle consumer src1=r5 -> stall=1 for 1 cycle and a bubble enters stage 0. Next cycle fwd_sel[1]=2, stall=0; stall_count=1 when the macro is defined.
3. Two back-to-back writes to r2 (A then B), then consumer src0=r2 -> fwd_sel[0]=1 (B, not A). If B is a load, stall=1 even though A is ready.
4. src_used=2'b01 with src1 matching an entry, or issue_valid=0 -> no forward on the unused source, stall=0. An issue with dst_wr_en=0 leaves a bubble, so a later consumer gets fwd_sel=0.
5. Entries populated, then flush together with pipe_hold -> next cycle all fwd_sel=0. Separately, pipe_hold alone for 3 cycles -> fwd_sel values unchanged.
6. Assert rst asynchronously mid-stream, between clock edges -> fwd_sel=0, stall=0 and stall_count=0 immediately; normal forwarding resumes after deassertion.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard unit.
package fwd_pkg;

    // Entries store addresses at this fixed width; the top zero-extends AW into it.
    localparam int unsigned FWD_ADDR_MAX = 8;
    localparam int unsigned FWD_SEL_RF   = 0;

    typedef struct packed {
        logic                    valid;
        logic [FWD_ADDR_MAX-1:0] addr;
        logic                    is_load;
    } fwd_entry_t;

    function automatic int unsigned fwd_sel_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_src_match.sv
// One source operand: compare against all in-flight tags, youngest match wins.
module fwd_src_match
    import fwd_pkg::*;
#(
    parameter int unsigned AW       = 3,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned SW       = 2
) (
    input  logic                            issue_valid,
    input  logic                            src_used,
    input  logic [AW-1:0]                   src_addr,
    input  logic [DEPTH-1:0]                ent_valid,
    input  logic [DEPTH-1:0]                ent_is_load,
    input  logic [DEPTH*FWD_ADDR_MAX-1:0]   ent_addr,
    output logic [SW-1:0]                   sel,
    output logic                            not_ready
);

    logic found;

    always_comb begin
        sel       = SW'(FWD_SEL_RF);
        not_ready = 1'b0;
        found     = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!found && ent_valid[i] && src_used && issue_valid &&
                (ent_addr[i*FWD_ADDR_MAX +: FWD_ADDR_MAX] == FWD_ADDR_MAX'(src_addr))) begin
                found = 1'b1;
                // A young load shadows any older ready producer of the same register.
                if (ent_is_load[i] && (i < LOAD_LAT)) begin
                    not_ready = 1'b1;
                end else begin
                    sel = SW'(i + 1);
                end
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall generation over a DEPTH-stage tag pipeline.
// Optional stall-cycle counter enabled by defining FWD_PERF_CNT_EN.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned AW       = 3,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_LAT = 1,
    localparam int unsigned SW      = fwd_sel_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [NUM_SRC*AW-1:0] src_addr,
    input  logic [NUM_SRC-1:0]    src_used,
    input  logic                  dst_wr_en,
    input  logic [AW-1:0]         dst_addr,
    input  logic                  dst_is_load,
    input  logic                  pipe_hold,
    input  logic                  flush,
    output logic [NUM_SRC*SW-1:0] fwd_sel,
    output logic                  stall,
    output logic [31:0]           stall_count
);

    if (AW > FWD_ADDR_MAX) begin : g_aw_check
        $error("AW exceeds FWD_ADDR_MAX");
    end

    fwd_entry_t entries_q [DEPTH];
    fwd_entry_t entries_d [DEPTH];

    logic [DEPTH-1:0]              ent_valid;
    logic [DEPTH-1:0]              ent_is_load;
    logic [DEPTH*FWD_ADDR_MAX-1:0] ent_addr;
    logic [NUM_SRC-1:0]            not_ready;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid[i]                                 = entries_q[i].valid;
            ent_is_load[i]                               = entries_q[i].is_load;
            ent_addr[i*FWD_ADDR_MAX +: FWD_ADDR_MAX]     = entries_q[i].addr;
        end
    end

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        fwd_src_match #(
            .AW       (AW),
            .DEPTH    (DEPTH),
            .LOAD_LAT (LOAD_LAT),
            .SW       (SW)
        ) u_match (
            .issue_valid (issue_valid),
            .src_used    (src_used[k]),
            .src_addr    (src_addr[k*AW +: AW]),
            .ent_valid   (ent_valid),
            .ent_is_load (ent_is_load),
            .ent_addr    (ent_addr),
            .sel         (fwd_sel[k*SW +: SW]),
            .not_ready   (not_ready[k])
        );
    end

    assign stall = |not_ready;

    always_comb begin
        entries_d = entries_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i] = '0;
            end
        end else if (!pipe_hold) begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                entries_d[i] = entries_q[i-1];
            end
            // A stalled instruction is not issued, so a bubble enters instead.
            entries_d[0] = '0;
            if (issue_valid && dst_wr_en && !stall) begin
                entries_d[0].valid   = 1'b1;
                entries_d[0].addr    = FWD_ADDR_MAX'(dst_addr);
                entries_d[0].is_load = dst_is_load;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            entries_q <= entries_d;
        end
    end

`ifdef FWD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !pipe_hold && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit with AW=3, NUM_SRC=2, DEPTH=3, LOAD_LAT=1.
module tb_fwd_hazard_unit;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [5:0]  src_addr;
    logic [1:0]  src_used;
    logic        dst_wr_en;
    logic [2:0]  dst_addr;
    logic        dst_is_load;
    logic        pipe_hold;
    logic        flush;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic [31:0] stall_count;

    typedef struct {
        logic [3:0] sel;
        logic       stall;
    } exp_t;

    exp_t        sb [$];
    int          checks  = 0;
    int          errors  = 0;
    int          step    = 0;
    logic [31:0] exp_cnt = '0;

    fwd_hazard_unit #(
        .AW       (3),
        .NUM_SRC  (2),
        .DEPTH    (3),
        .LOAD_LAT (1)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .src_addr    (src_addr),
        .src_used    (src_used),
        .dst_wr_en   (dst_wr_en),
        .dst_addr    (dst_addr),
        .dst_is_load (dst_is_load),
        .pipe_hold   (pipe_hold),
        .flush       (flush),
        .fwd_sel     (fwd_sel),
        .stall       (stall),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %0h expected %0h", tag, step, got, exp);
        end
    endtask

    // One issue cycle: drive, push expectation, compare before the edge, then clock.
    task automatic cyc(input logic iv, input logic [2:0] s0, input logic [2:0] s1,
                       input logic [1:0] used, input logic wr, input logic [2:0] dst,
                       input logic ld, input logic hold, input logic fl,
                       input logic [1:0] e0, input logic [1:0] e1, input logic es);
        exp_t e;
        step++;
        issue_valid = iv;
        src_addr    = {s1, s0};
        src_used    = used;
        dst_wr_en   = wr;
        dst_addr    = dst;
        dst_is_load = ld;
        pipe_hold   = hold;
        flush       = fl;
        e.sel       = {e1, e0};
        e.stall     = es;
        sb.push_back(e);
        #3;
        if (sb.size() == 0) begin
            check_eq("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check_eq("fwd_sel", 32'(fwd_sel), 32'(e.sel));
            check_eq("stall", 32'(stall), 32'(e.stall));
            check_eq("stall_count", stall_count, exp_cnt);
        end
        @(posedge clk);
        #1;
`ifdef FWD_PERF_CNT_EN
        if (es && !hold) exp_cnt++;
`endif
    endtask

    initial begin
        rst         = 1'b1;
        issue_valid = 1'b1;
        src_addr    = 6'o33;
        src_used    = 2'b11;
        dst_wr_en   = 1'b0;
        dst_addr    = '0;
        dst_is_load = 1'b0;
        pipe_hold   = 1'b0;
        flush       = 1'b0;
        #2;
        check_eq("reset_sel", 32'(fwd_sel), 32'd0);
        check_eq("reset_stall", 32'(stall), 32'd0);
        check_eq("reset_cnt", stall_count, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ALU r3 then consumer at distances 1..4
        cyc(1, 0, 0, 2'b00, 1, 3, 0, 0, 0, 0, 0, 0);
        cyc(1, 3, 0, 2'b01, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 3, 0, 2'b01, 0, 0, 0, 0, 0, 2, 0, 0);
        cyc(1, 3, 0, 2'b01, 0, 0, 0, 0, 0, 3, 0, 0);
        cyc(1, 3, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);

        // Load-use: one stall, bubble, then forward from stage 1
        cyc(1, 0, 0, 2'b00, 1, 5, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 5, 2'b10, 1, 6, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 5, 2'b10, 1, 6, 0, 0, 0, 0, 2, 0);
        cyc(1, 6, 5, 2'b11, 0, 0, 0, 0, 0, 1, 3, 0);
        cyc(0, 6, 6, 2'b11, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 6, 6, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0);

        // Youngest writer wins; own destination not self-matched
        cyc(1, 2, 0, 2'b01, 1, 2, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 2'b00, 1, 2, 0, 0, 0, 0, 0, 0);
        cyc(1, 2, 0, 2'b01, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 2'b00, 1, 2, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 2'b00, 1, 2, 1, 0, 0, 0, 0, 0);
        cyc(1, 2, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 2, 0, 2'b01, 0, 0, 0, 0, 0, 2, 0, 0);

        // Unused source ignores a young load; dst_wr_en=0 leaves a bubble
        cyc(1, 0, 0, 2'b00, 1, 4, 1, 0, 0, 0, 0, 0);
        cyc(1, 7, 4, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 4, 2'b11, 0, 0, 0, 0, 0, 0, 3, 0);

        // Hold keeps selects, flush beats hold; r0 forwards like any register
        cyc(1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 2'b00, 1, 2, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 2'b00, 1, 3, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 3, 2'b11, 0, 0, 0, 1, 0, 3, 1, 0);
        end
        cyc(1, 0, 3, 2'b11, 0, 0, 0, 1, 1, 3, 1, 0);
        cyc(1, 0, 3, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-cycle, then normal operation resumes
        cyc(1, 0, 0, 2'b00, 1, 5, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 2'b00, 1, 6, 0, 0, 0, 0, 0, 0);
        cyc(1, 6, 5, 2'b11, 0, 0, 0, 0, 0, 1, 2, 0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_sel", 32'(fwd_sel), 32'd0);
        check_eq("async_rst_stall", 32'(stall), 32'd0);
        check_eq("async_rst_cnt", stall_count, 32'd0);
        exp_cnt = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1, 0, 0, 2'b00, 1, 3, 0, 0, 0, 0, 0, 0);
        cyc(1, 3, 0, 2'b01, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 2'b00, 1, 5, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 5, 2'b10, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 5, 2'b10, 0, 0, 0, 0, 0, 0, 2, 0);

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
